// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline controller: FSM state encoding, NOP
// encoding and a saturating counter helper.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_IO_WAIT = 2'd2
  } state_e;

  // addi x0, x0, 0 -- the bubble instruction loaded by the flush controls
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard compare: a load in Execute whose destination is read by
// the instruction currently in Decode.
module hazard_detect (
  input  logic [4:0] d_ra1_i,
  input  logic [4:0] d_ra2_i,
  input  logic       d_use1_i,
  input  logic       d_use2_i,
  input  logic [4:0] e_wa_i,
  input  logic       e_regwen_i,
  input  logic       e_is_load_i,
  output logic       lu_o
);

  // x0 is hard-wired to zero, so a load targeting it never creates a hazard
  assign lu_o = e_is_load_i & e_regwen_i & (e_wa_i != 5'd0) &
                ((d_use1_i & (d_ra1_i == e_wa_i)) |
                 (d_use2_i & (d_ra2_i == e_wa_i)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: boot bubbles, load-use stalls, branch
// redirects and I/O-wait freezing with timeout, plus performance counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned IO_TIMEOUT   = 1024,
  parameter int unsigned BOOT_BUBBLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  d_ra1,
  input  logic [4:0]  d_ra2,
  input  logic        d_use1,
  input  logic        d_use2,
  input  logic [4:0]  e_wa,
  input  logic        e_regwen,
  input  logic        e_is_load,
  input  logic        e_redirect,
  input  logic        m_io_req,
  input  logic        io_ready,
  output logic        pc_en,
  output logic        fd_en,
  output logic        de_en,
  output logic        em_en,
  output logic        mw_en,
  output logic        fd_flush,
  output logic        de_flush,
  output logic        mw_flush,
  output logic        pc_redirect,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
  output logic        io_timeout
);

  localparam logic [2:0]  BOOT_LAST = 3'(BOOT_BUBBLES - 1);
  localparam logic [15:0] WAIT_LAST = 16'(IO_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [2:0]  boot_cnt_q, boot_cnt_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic        io_timeout_q, io_timeout_d;
  logic        lu, freeze, advance;

  hazard_detect u_hazard (
    .d_ra1_i     (d_ra1),
    .d_ra2_i     (d_ra2),
    .d_use1_i    (d_use1),
    .d_use2_i    (d_use2),
    .e_wa_i      (e_wa),
    .e_regwen_i  (e_regwen),
    .e_is_load_i (e_is_load),
    .lu_o        (lu)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    pc_en        = 1'b1;
    fd_en        = 1'b1;
    de_en        = 1'b1;
    em_en        = 1'b1;
    mw_en        = 1'b1;
    fd_flush     = 1'b0;
    de_flush     = 1'b0;
    mw_flush     = 1'b0;
    pc_redirect  = 1'b0;
    freeze       = 1'b0;
    advance      = 1'b0;
    state_d      = state_q;
    boot_cnt_d   = boot_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    io_timeout_d = io_timeout_q;

    unique case (state_q)
      ST_BOOT: begin
        fd_flush   = 1'b1;
        de_flush   = 1'b1;
        boot_cnt_d = boot_cnt_q + 3'd1;
        if (boot_cnt_q == BOOT_LAST) begin
          state_d    = ST_RUN;
          boot_cnt_d = '0;
        end
      end
      ST_RUN: begin
        if (m_io_req && !io_ready) begin
          freeze     = 1'b1;
          state_d    = ST_IO_WAIT;
          wait_cnt_d = '0;
        end else begin
          advance = 1'b1;
        end
      end
      ST_IO_WAIT: begin
        if (io_ready || wait_cnt_q == WAIT_LAST) begin
          advance = 1'b1;
          state_d = ST_RUN;
          if (!io_ready) io_timeout_d = 1'b1;
        end else begin
          freeze     = 1'b1;
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      default: state_d = ST_BOOT;
    endcase

    if (freeze) begin
      {pc_en, fd_en, de_en, em_en, mw_en} = 5'b0;
      mw_flush    = 1'b1;
      stall_cnt_d = sat_inc(stall_cnt_q);
    end

    // A redirect kills the Decode instruction, so its load-use stall is moot
    if (advance) begin
      if (e_redirect) begin
        pc_redirect = 1'b1;
        fd_flush    = 1'b1;
        de_flush    = 1'b1;
        flush_cnt_d = sat_inc(flush_cnt_q);
      end else if (lu) begin
        pc_en       = 1'b0;
        fd_en       = 1'b0;
        de_flush    = 1'b1;
        stall_cnt_d = sat_inc(stall_cnt_q);
      end
    end

    if (rst) begin
      {pc_en, fd_en, de_en, em_en, mw_en} = 5'b11111;
      fd_flush    = 1'b1;
      de_flush    = 1'b1;
      mw_flush    = 1'b0;
      pc_redirect = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_BOOT;
      boot_cnt_q   <= '0;
      wait_cnt_q   <= '0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      io_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      boot_cnt_q   <= boot_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      io_timeout_q <= io_timeout_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;
  assign io_timeout = io_timeout_q;

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter: IO_TIMEOUT, 1024, max cycles held in IO_WAIT before forced release (range 2..65535).
REQ-002 Parameter: BOOT_BUBBLES, 2, bubble cycles issued after reset while synchronous memories fill (range 1..7).
REQ-003 Ports: clk  in  1  sole clock; all state updates on rising edge.
REQ-004 Ports: rst  in  1  reset, synchronous, active-high.
REQ-005 Ports: d_ra1, d_ra2  in  5 each  Decode-stage source register addresses.
REQ-006 Ports: d_use1, d_use2  in  1 each  Decode instruction reads rs1/rs2.
REQ-007 Ports: e_wa  in  5  Execute-stage destination; e_regwen  in  1; e_is_load  in  1.
REQ-008 Ports: e_redirect  in  1  taken branch/jump resolved in Execute.
REQ-009 Ports: m_io_req  in  1  Memory stage accesses I/O space; io_ready  in  1  I/O device completes access.
REQ-010 Ports: pc_en, fd_en, de_en, em_en, mw_en  out  1 each  pipeline-register load enables.
REQ-011 Ports: fd_flush, de_flush, mw_flush  out  1 each  load a NOP/zero-control bubble into that register.
REQ-012 Ports: pc_redirect  out  1  PC loads the Execute target instead of PC+4.
REQ-013 Ports: stall_cnt, flush_cnt  out  32 each  performance counters; io_timeout  out  1  sticky error flag.

Function
REQ-014 FSM states: BOOT, RUN, IO_WAIT; state and counters are registered, and all enable/flush outputs are combinational from state plus current inputs.
REQ-015 BOOT: all enables 1, fd_flush=de_flush=1, pc_redirect=0; a 3-bit counter leaves BOOT to RUN after exactly BOOT_BUBBLES cycles.
REQ-016 Load-use hazard (lu) = e_is_load & e_regwen & (e_wa!=0) & ((d_use1 & d_ra1==e_wa) | (d_use2 & d_ra2==e_wa)).
REQ-017 RUN, lu=1, e_redirect=0: pc_en=fd_en=0, de_flush=1, others enabled; stall lasts exactly one cycle because the load advances.
REQ-018 RUN, e_redirect=1: pc_redirect=1, fd_flush=de_flush=1, all enables 1; redirect overrides lu in the same cycle, with no stall.
REQ-019 RUN, m_io_req=1, io_ready=0: all enables 0, mw_flush=1, pc_redirect=0; next state is IO_WAIT; this has priority over redirect and lu.
REQ-020 RUN, m_io_req=1, io_ready=1 in the same cycle: treated as zero-wait, so the RUN rules of REQ-017/018 apply.
REQ-021 IO_WAIT: freeze as in REQ-019 while io_ready=0; a 16-bit wait counter increments each cycle.
REQ-022 IO_WAIT, io_ready=1: pipeline advances this cycle using the RUN rules (redirect/lu still held in E/D are honoured), and next state is RUN.
REQ-023 IO_WAIT when the wait counter reaches IO_TIMEOUT-1: the pipeline advances as if io_ready=1, io_timeout is set (sticky), and next state is RUN.
REQ-024 stall_cnt +1 on each lu-stall cycle and each freeze cycle; flush_cnt +1 on each cycle with pc_redirect=1; both saturate at 0xFFFFFFFF.
REQ-025 Outputs have no latency beyond the combinational path; a freeze request seen in cycle N blocks the edge at the end of cycle N.

Reset
REQ-026 rst=1 at any edge, including mid-IO_WAIT or mid-BOOT: state=BOOT, boot and wait counters=0, stall_cnt=flush_cnt=0, io_timeout=0.
REQ-027 While rst=1 the outputs follow BOOT values: enables 1, fd_flush=de_flush=1, mw_flush=0, pc_redirect=0.

Structure
REQ-028 The state encoding (BOOT=2'd0, RUN=2'd1, IO_WAIT=2'd2) and the NOP encoding 32'h0000_0013 shall be placed in the shared define header beside the existing PCSel/WBSel defines.
REQ-029 One sub-module, hazard_detect (purely combinational lu compare, REQ-016), shall be used; the FSM and counters stay in pipeline_ctrl.

Verification
REQ-030 Reset release: rst high for 3 cycles, then low -> fd_flush=de_flush=1 for exactly 2 cycles, then 0; stall_cnt=0.
REQ-031 Load-use: e_is_load=1, e_regwen=1, e_wa=5, d_ra1=5, d_use1=1 for 1 cycle -> pc_en=fd_en=0, de_flush=1 in that cycle; stall_cnt=1.
REQ-032 Load-use with e_wa=0 or d_use1=0 -> no stall; redirect+lu in the same cycle -> pc_redirect=1, pc_en=1, flush_cnt=1, stall_cnt=0.
REQ-033 I/O wait: m_io_req=1, io_ready=0 for 4 cycles, then 1 -> all enables 0 for 4 cycles, advance in cycle 5, state back to RUN; stall_cnt=4.
REQ-034 Timeout: IO_TIMEOUT=8, io_ready held 0 -> release on the 8th IO_WAIT cycle, io_timeout=1 and stays 1 until rst.
REQ-035 rst asserted during the 2nd IO_WAIT cycle -> next cycle state=BOOT, counters 0, io_timeout=0.
